// File: rtl/uart_pkg.sv
// Shared UART definitions: frame sequencer state encoding and default widths,
// used by both the TX and RX controllers.
package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DIV_WIDTH_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period down-counter: restarts at div-1 (div 0 acts as 1), counts to 0,
// flags bit_end on 0 and reloads itself for the following bit.
module uart_baud_cnt #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 restart,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 bit_end
);

  logic [DIV_WIDTH-1:0] count_q;
  logic [DIV_WIDTH-1:0] reload_val;

  assign reload_val = (div == '0) ? '0 : div - DIV_WIDTH'(1);
  assign bit_end    = (count_q == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else if (restart || bit_end) begin
      count_q <= reload_val;
    end else begin
      count_q <= count_q - DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops one FIFO word per frame and serialises it as
// start, data (LSB first), optional parity and one or two stop bits.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DIV_WIDTH  = DIV_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  tx_en_i,
  input  logic [DIV_WIDTH-1:0]  baud_div_i,
  input  logic                  par_en_i,
  input  logic                  par_odd_i,
  input  logic                  stop2_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  input  logic                  fifo_valid_i,
  output logic                  fifo_ready_o,
  output logic                  txd_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  // Handshake: a pop happens in any cycle where fifo_valid_i & fifo_ready_o;
  // the popped word is presented on fifo_data_i during the following cycle.
  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DIV_WIDTH-1:0]  div_q, div_sel;
  logic                  par_en_q, par_bit_q, stop2_q;
  logic                  txd_q, txd_d;
  logic                  done_q, done_d;
  logic                  bit_end, baud_restart;

  assign fifo_ready_o = (state_q == IDLE) && tx_en_i;
  assign txd_o        = txd_q;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;

  // The divisor being latched in LOAD is needed by the counter at that same edge.
  assign div_sel      = (state_q == LOAD) ? baud_div_i : div_q;
  assign baud_restart = (state_d != state_q);

  uart_baud_cnt #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
    .clk     (clk),
    .rstn    (rstn),
    .restart (baud_restart),
    .div     (div_sel),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE:   if (fifo_valid_i && fifo_ready_o) state_d = LOAD;
      LOAD: begin
        shreg_d   = fifo_data_i;
        bit_cnt_d = '0;
        state_d   = START;
      end
      START:  if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP: begin
        if (bit_end) begin
          if (stop2_q && (bit_cnt_q == '0)) begin
            bit_cnt_d = CNT_W'(1);
          end else begin
            bit_cnt_d = '0;
            state_d   = IDLE;
            done_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is registered from the next state so it changes with the state.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shreg_d[0];
      PARITY:  txd_d = par_bit_q;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      txd_q     <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      txd_q     <= txd_d;
      done_q    <= done_d;
      if (state_q == LOAD) begin
        div_q     <= baud_div_i;
        par_en_q  <= par_en_i;
        par_bit_q <= (^fifo_data_i) ^ par_odd_i;
        stop2_q   <= stop2_i;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: per-cycle scoreboard of line/busy/done/ready built
// from whole-frame descriptions, plus a table of hand-computed frames.
module tb_uart_tx_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        tx_en_i;
  logic [15:0] baud_div_i;
  logic        par_en_i, par_odd_i, stop2_i;
  logic [7:0]  fifo_data_i = 8'h00;
  logic        fifo_valid_i = 1'b0;
  logic        fifo_ready_o, txd_o, busy_o, done_o;

  uart_tx_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .tx_en_i      (tx_en_i),
    .baud_div_i   (baud_div_i),
    .par_en_i     (par_en_i),
    .par_odd_i    (par_odd_i),
    .stop2_i      (stop2_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_valid_i (fifo_valid_i),
    .fifo_ready_o (fifo_ready_o),
    .txd_o        (txd_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  int         pops = 0;
  int         done_cnt = 0;
  logic       chk_en = 1'b0;
  logic [7:0] tbq[$];         // FIFO contents
  logic [2:0] exp_q[$];       // per-cycle {txd, busy, done}
  logic       load_next = 1'b0;
  logic [7:0] pend = 8'h00;
  logic       exp_rdy = 1'b0;
  logic [2:0] exp_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // A frame is LOAD (line idle, busy), then each line bit for max(div,1)
  // cycles, then one idle cycle carrying the done pulse.
  function automatic void push_frame(input logic [7:0] b);
    int   d;
    logic bits[$];
    d = (baud_div_i == 16'd0) ? 1 : int'(baud_div_i);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (par_en_i) bits.push_back((^b) ^ par_odd_i);
    bits.push_back(1'b1);
    if (stop2_i) bits.push_back(1'b1);
    exp_q.push_back(3'b110);
    for (int i = 0; i < bits.size(); i++)
      for (int j = 0; j < d; j++) exp_q.push_back({bits[i], 2'b10});
    exp_q.push_back(3'b101);
  endfunction

  // Scoreboard and FIFO model, both mid-cycle after the negedge stimulus.
  always begin
    @(negedge clk);
    #1;
    if (chk_en) begin
      exp_e   = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b100;
      exp_rdy = tx_en_i & ~exp_e[1];
      check("cycle", 32'({txd_o, busy_o, done_o, fifo_ready_o}), 32'({exp_e, exp_rdy}));
      if (done_o) done_cnt++;
    end else begin
      exp_rdy = 1'b0;
    end
    #1;
    fifo_data_i  = load_next ? pend : 8'($urandom);
    load_next    = 1'b0;
    fifo_valid_i = (tbq.size() > 0);
    if (chk_en && rstn && exp_rdy && fifo_valid_i) begin
      pend      = tbq.pop_front();
      load_next = 1'b1;
      pops++;
      push_frame(pend);
    end
  end

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((tbq.size() != 0 || exp_q.size() != 0) && n < max_cyc);
    check("idle_timeout", 32'(n >= max_cyc), 32'd0);
  endtask

  task automatic wait_pop(input int p0);
    int n = 0;
    while (pops == p0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("pop_timeout", 32'(n >= 100), 32'd0);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    logic        par_en, par_odd, stop2;
    logic [11:0] frame;   // bit k = k-th line bit of the frame
    int          len;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int p0, d0, d;
    logic [11:0] got;

    vecs[0] = '{8'hA5, 16'd4, 1'b0, 1'b0, 1'b0, {2'b00, 1'b1, 8'hA5, 1'b0}, 10};
    vecs[1] = '{8'hA5, 16'd3, 1'b1, 1'b0, 1'b0, {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11};
    vecs[2] = '{8'hA5, 16'd2, 1'b1, 1'b1, 1'b0, {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11};
    vecs[3] = '{8'h07, 16'd2, 1'b1, 1'b0, 1'b0, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11};
    vecs[4] = '{8'h55, 16'd0, 1'b0, 1'b0, 1'b0, {2'b00, 1'b1, 8'h55, 1'b0}, 10};
    vecs[5] = '{8'h55, 16'd1, 1'b0, 1'b0, 1'b1, {1'b0, 2'b11, 8'h55, 1'b0}, 11};
    vecs[6] = '{8'h00, 16'd2, 1'b0, 1'b0, 1'b1, {1'b0, 2'b11, 8'h00, 1'b0}, 11};
    vecs[7] = '{8'hFF, 16'd5, 1'b1, 1'b1, 1'b1, {2'b11, 1'b1, 8'hFF, 1'b0}, 12};

    rstn = 1'b0; tx_en_i = 1'b0; baud_div_i = 16'd4;
    par_en_i = 1'b0; par_odd_i = 1'b0; stop2_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_txd", 32'(txd_o), 32'd1);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_done", 32'(done_o), 32'd0);
    @(negedge clk);
    rstn = 1'b1; chk_en = 1'b1; tx_en_i = 1'b1;

    // Hand-computed frames.
    for (int v = 0; v < 8; v++) begin
      wait_idle(200);
      baud_div_i = vecs[v].div; par_en_i = vecs[v].par_en;
      par_odd_i = vecs[v].par_odd; stop2_i = vecs[v].stop2;
      p0 = pops;
      tbq.push_back(vecs[v].data);
      wait_pop(p0);
      d = (vecs[v].div == 16'd0) ? 1 : int'(vecs[v].div);
      got = '0;
      for (int k = 0; k < vecs[v].len; k++) begin
        repeat ((k == 0) ? 1 : d) @(negedge clk);
        #1;
        got[k] = txd_o;
      end
      repeat (d) @(negedge clk);
      #1;
      check("vec_done", 32'(done_o), 32'd1);
      check("vec_frame", 32'(got), 32'(vecs[v].frame));
    end

    // Two stop bits with back-to-back frames.
    wait_idle(200);
    baud_div_i = 16'd2; stop2_i = 1'b1; par_en_i = 1'b0;
    p0 = pops; d0 = done_cnt;
    tbq.push_back(8'h00); tbq.push_back(8'hFF);
    wait_idle(200);
    check("b2b_pops", 32'(pops - p0), 32'd2);
    check("b2b_dones", 32'(done_cnt - d0), 32'd2);

    // Divisor and enable change during DATA.
    baud_div_i = 16'd3; stop2_i = 1'b0;
    p0 = pops;
    tbq.push_back(8'h3C); tbq.push_back(8'hC3);
    wait_pop(p0);
    repeat (1 + 3 + 3 * 2) @(negedge clk);
    baud_div_i = 16'd7; tx_en_i = 1'b0;
    repeat (60) @(negedge clk);
    check("midcfg_pops", 32'(pops - p0), 32'd1);
    check("midcfg_left", 32'(tbq.size()), 32'd1);
    tx_en_i = 1'b1;
    wait_idle(300);

    // Reset during DATA bit 3.
    baud_div_i = 16'd4;
    p0 = pops; d0 = done_cnt;
    tbq.push_back(8'h96); tbq.push_back(8'h69);
    wait_pop(p0);
    repeat (1 + 4 + 4 * 3 + 1) @(negedge clk);
    chk_en = 1'b0; rstn = 1'b0;
    exp_q.delete();
    #3;
    check("abort_txd", 32'(txd_o), 32'd1);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_done", 32'(done_o), 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1; chk_en = 1'b1;
    wait_idle(300);
    check("abort_pops", 32'(pops - p0), 32'd2);
    check("abort_dones", 32'(done_cnt - d0), 32'd1);

    // Random bursts with random config and a flickering enable.
    for (int r = 0; r < 40; r++) begin
      int n, nb;
      baud_div_i = 16'($urandom_range(0, 5));
      par_en_i = 1'($urandom_range(0, 1));
      par_odd_i = 1'($urandom_range(0, 1));
      stop2_i = 1'($urandom_range(0, 1));
      nb = $urandom_range(1, 3);
      for (int i = 0; i < nb; i++) tbq.push_back(8'($urandom));
      n = 0;
      while ((tbq.size() != 0 || exp_q.size() != 0) && n < 2000) begin
        tx_en_i = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        n++;
      end
      tx_en_i = 1'b1;
      check("rand_timeout", 32'(n >= 2000), 32'd0);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
